sd_dat_block_rx: RTL and testbench

Host-side SD DAT-line block receiver. It is armed after a CMD17-style read has been issued. It then hunts for the start bit, deserialises one data block of BLOCK_BYTES bytes from a 1- or 4-lane DAT bus, checks the per-lane CRC16 and end bit, and streams bytes to the downstream SRAM/pixel path. It replaces the fixed 4-bit, fixed-size nibble capture in the SD edge-detection datapath, and adds bus-width, block-size, timeout and integrity-checking options.

---
 rtl/sd_dat_block_rx.sv | 186 ++++++++++++++++++
 tb/tb_sd_dat_block_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_block_rx.sv
// SD DAT-line block receiver: hunts for the start bit, deserialises one block from 1 or 4 lanes,
// checks the per-lane CRC16 and the end bit, and streams the payload out byte by byte.
module sd_dat_block_rx #(
  parameter int unsigned DAT_WIDTH      = 4,
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DAT_WIDTH-1:0] dat_in,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  output logic [((BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1)-1:0] byte_index,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_error,
  output logic                 timeout
);

  localparam int unsigned IdxW       = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int unsigned DataCycles = BLOCK_BYTES * 8 / DAT_WIDTH;
  localparam int unsigned CntMax     = (DataCycles > 16) ? DataCycles : 16;
  localparam int unsigned CntW       = $clog2(CntMax);
  localparam int unsigned WaitW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned Spb        = 8 / DAT_WIDTH;
  localparam int unsigned ShW        = 8 - DAT_WIDTH;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StCrc  = 3'd3;
  localparam logic [2:0] StEnd  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]       samp_q, samp_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [ShW-1:0]   shift_q, shift_d;
  logic [15:0]      crc_q [DAT_WIDTH];
  logic [15:0]      crc_d [DAT_WIDTH];
  logic [IdxW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic [IdxW-1:0]  byte_index_q, byte_index_d;
  logic             byte_valid_q, byte_valid_d;
  logic             done_q, done_d;
  logic             crc_error_q, crc_error_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       byte_now;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign byte_now = {shift_q, dat_in};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    wait_cnt_d   = wait_cnt_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    byte_data_d  = byte_data_q;
    byte_index_d = byte_index_q;
    byte_valid_d = 1'b0;
    done_d       = 1'b0;
    crc_error_d  = crc_error_q;
    timeout_d    = timeout_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d      = StWait;
          crc_error_d  = 1'b0;
          timeout_d    = 1'b0;
          wait_cnt_d   = '0;
          bit_cnt_d    = '0;
          samp_d       = '0;
          byte_cnt_d   = '0;
          byte_index_d = '0;
          for (int l = 0; l < DAT_WIDTH; l++) crc_d[l] = '0;
        end
      end
      StWait: begin
        if (dat_in == '0) begin
          state_d   = StData;
          bit_cnt_d = '0;
          samp_d    = '0;
        end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          timeout_d  = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StData: begin
        shift_d = byte_now[ShW-1:0];
        for (int l = 0; l < DAT_WIDTH; l++) crc_d[l] = crc16_step(crc_q[l], dat_in[l]);
        samp_d = samp_q + 1'b1;
        if (samp_q == 3'(Spb - 1)) begin
          byte_data_d  = byte_now;
          byte_index_d = byte_cnt_q;
          byte_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + 1'b1;
          samp_d       = '0;
        end
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(DataCycles - 1)) begin
          state_d   = StCrc;
          bit_cnt_d = '0;
        end
      end
      StCrc: begin
        // Received CRC arrives MSB first; compare against the top bit and shift it away.
        for (int l = 0; l < DAT_WIDTH; l++) begin
          if (dat_in[l] != crc_q[l][15]) crc_error_d = 1'b1;
          crc_d[l] = {crc_q[l][14:0], 1'b0};
        end
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(15)) state_d = StEnd;
      end
      StEnd: begin
        if (dat_in != '1) crc_error_d = 1'b1;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d      = StIdle;
      done_d       = 1'b0;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      byte_index_d = byte_index_q;
      crc_error_d  = crc_error_q;
      timeout_d    = timeout_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      wait_cnt_q   <= '0;
      shift_q      <= '0;
      for (int l = 0; l < DAT_WIDTH; l++) crc_q[l] <= '0;
      byte_cnt_q   <= '0;
      byte_data_q  <= '0;
      byte_index_q <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      crc_error_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      wait_cnt_q   <= wait_cnt_d;
      shift_q      <= shift_d;
      for (int l = 0; l < DAT_WIDTH; l++) crc_q[l] <= crc_d[l];
      byte_cnt_q   <= byte_cnt_d;
      byte_data_q  <= byte_data_d;
      byte_index_q <= byte_index_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      crc_error_q  <= crc_error_d;
      timeout_q    <= timeout_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_index = byte_index_q;
  assign byte_valid = byte_valid_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign crc_error  = crc_error_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Scoreboard bench for sd_dat_block_rx: a 4-lane 3-byte instance and a 1-lane 512-byte instance.
module tb_sd_dat_block_rx;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 4-lane, 3-byte, 20-cycle timeout instance
  logic       start4, abort4;
  logic [3:0] dat4;
  logic [7:0] bd4;
  logic [1:0] bi4;
  logic       bv4, busy4, dn4, ce4, to4;

  // 1-lane, 512-byte instance
  logic       start1, abort1;
  logic [0:0] dat1;
  logic [7:0] bd1;
  logic [8:0] bi1;
  logic       bv1, busy1, dn1, ce1, to1;

  sd_dat_block_rx #(.DAT_WIDTH(4), .BLOCK_BYTES(3), .TIMEOUT_CYCLES(20)) dut4 (
    .clk(clk), .n_rst(n_rst), .start(start4), .abort(abort4), .dat_in(dat4),
    .byte_data(bd4), .byte_valid(bv4), .byte_index(bi4), .busy(busy4), .done(dn4),
    .crc_error(ce4), .timeout(to4)
  );

  sd_dat_block_rx #(.DAT_WIDTH(1), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .abort(abort1), .dat_in(dat1),
    .byte_data(bd1), .byte_valid(bv1), .byte_index(bi1), .busy(busy1), .done(dn1),
    .crc_error(ce1), .timeout(to1)
  );

  // Scoreboard queues: expected bytes and expected {crc_error, timeout} at each done
  int         exp4_idx[$];
  logic [7:0] exp4_dat[$];
  logic [1:0] exp4_done[$];
  int         exp1_idx[$];
  logic [7:0] exp1_dat[$];
  logic [1:0] exp1_done[$];
  logic [7:0] blk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (n_rst) begin
      if (bv4) begin
        if (exp4_dat.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut4_unexpected_strobe actual=%0h required=none", bd4);
        end else begin
          chk("dut4_byte_data", bd4, exp4_dat.pop_front());
          chk("dut4_byte_index", bi4, exp4_idx.pop_front());
        end
      end
      if (dn4) begin
        if (exp4_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut4_unexpected_done actual=1 required=0");
        end else chk("dut4_done_flags", {ce4, to4}, exp4_done.pop_front());
      end
      if (bv1) begin
        if (exp1_dat.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut1_unexpected_strobe actual=%0h required=none", bd1);
        end else begin
          chk("dut1_byte_data", bd1, exp1_dat.pop_front());
          chk("dut1_byte_index", bi1, exp1_idx.pop_front());
        end
      end
      if (dn1) begin
        if (exp1_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut1_unexpected_done actual=1 required=0");
        end else chk("dut1_done_flags", {ce1, to1}, exp1_done.pop_front());
      end
    end
  end

  // Sends blk on the 4-lane instance with matching CRCs; start_at pulses start mid-DATA.
  task automatic run4(input logic [3:0] endv, input int start_at);
    logic [15:0] c[4];
    logic [3:0]  n;
    for (int l = 0; l < 4; l++) c[l] = '0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    dat4 = 4'h0; tick();
    for (int b = 0; b < blk.size(); b++) begin
      for (int h = 0; h < 2; h++) begin
        n = (h == 0) ? blk[b][7:4] : blk[b][3:0];
        dat4 = n;
        for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], n[l]);
        start4 = (b * 2 + h == start_at);
        tick();
      end
    end
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 4; l++) dat4[l] = c[l][15-i];
      tick();
    end
    dat4 = endv; tick();
    dat4 = 4'hF; tick(); tick();
  endtask

  // 512 bytes of 0xFF on the 1-lane instance with an explicit CRC
  task automatic run1(input logic [15:0] crcv);
    start1 = 1'b1; tick(); start1 = 1'b0;
    dat1 = 1'b0; tick();
    for (int i = 0; i < 4096; i++) begin dat1 = 1'b1; tick(); end
    for (int i = 0; i < 16; i++) begin dat1 = crcv[15-i]; tick(); end
    dat1 = 1'b1; tick(); tick(); tick();
  endtask

  task automatic push4(input int idx, input logic [7:0] d);
    exp4_idx.push_back(idx);
    exp4_dat.push_back(d);
  endtask

  initial begin
    int k_done;
    n_rst = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; dat4 = 4'hF;
    start1 = 1'b0; abort1 = 1'b0; dat1 = 1'b1;
    tick(); tick();
    chk("reset_busy4", busy4, 0);
    chk("reset_outs4", {bd4, bi4, bv4, dn4, ce4, to4}, 0);
    chk("reset_outs1", {bd1, bi1, bv1, busy1, dn1, ce1, to1}, 0);
    n_rst = 1'b1; tick();

    // Basic 4-lane capture
    blk = '{8'h42, 8'h4D, 8'h36};
    push4(0, 8'h42); push4(1, 8'h4D); push4(2, 8'h36);
    exp4_done.push_back(2'b00);
    run4(4'hF, -1);
    chk("t1_busy_after", busy4, 0);

    // Known 1-lane CRC, good then bad
    for (int b = 0; b < 512; b++) begin exp1_idx.push_back(b); exp1_dat.push_back(8'hFF); end
    exp1_done.push_back(2'b00);
    run1(16'h7FA1);
    chk("t2_crc_ok", ce1, 0);
    for (int b = 0; b < 512; b++) begin exp1_idx.push_back(b); exp1_dat.push_back(8'hFF); end
    exp1_done.push_back(2'b10);
    run1(16'h7FA0);
    chk("t2_crc_bad_sticky", ce1, 1);

    // Bad end bit on an all-zero block
    blk = '{8'h00, 8'h00, 8'h00};
    push4(0, 8'h00); push4(1, 8'h00); push4(2, 8'h00);
    exp4_done.push_back(2'b10);
    run4(4'h7, -1);
    chk("t3_crc_error_sticky", ce4, 1);

    // Timeout: done exactly 20 cycles after entering WAIT_START
    exp4_done.push_back(2'b01);
    dat4 = 4'hF;
    start4 = 1'b1; tick(); start4 = 1'b0;
    chk("t4_crc_error_cleared", ce4, 0);
    k_done = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 19) chk("t4_busy_at_19", busy4, 1);
      if (dn4 && k_done < 0) k_done = k;
    end
    chk("t4_latency", k_done, 20);
    chk("t4_timeout_flag", to4, 1);
    chk("t4_busy_after", busy4, 0);
    start4 = 1'b1; tick(); start4 = 1'b0;
    chk("t4_timeout_cleared", to4, 0);
    chk("t4_rearmed", busy4, 1);
    abort4 = 1'b1; tick(); abort4 = 1'b0;
    chk("t4_abort_idle", busy4, 0);

    // abort beats start in IDLE
    abort4 = 1'b1; start4 = 1'b1; tick(); abort4 = 1'b0; start4 = 1'b0;
    chk("t5_abort_wins", busy4, 0);

    // Abort after byte 1 of 3
    push4(0, 8'hA5); push4(1, 8'h3C);
    start4 = 1'b1; tick(); start4 = 1'b0;
    dat4 = 4'h0; tick();
    dat4 = 4'hA; tick(); dat4 = 4'h5; tick();
    dat4 = 4'h3; tick(); dat4 = 4'hC; tick();
    abort4 = 1'b1; dat4 = 4'h7; tick(); abort4 = 1'b0;
    chk("t5_abort_busy", busy4, 0);
    dat4 = 4'h1; tick(); dat4 = 4'h2; tick(); dat4 = 4'hF;
    for (int i = 0; i < 20; i++) tick();

    // start during DATA is ignored
    blk = '{8'h11, 8'h22, 8'h33};
    push4(0, 8'h11); push4(1, 8'h22); push4(2, 8'h33);
    exp4_done.push_back(2'b00);
    run4(4'hF, 2);

    // Reset during CRC state
    push4(0, 8'h5A); push4(1, 8'hC3); push4(2, 8'h0F);
    start4 = 1'b1; tick(); start4 = 1'b0;
    dat4 = 4'h0; tick();
    dat4 = 4'h5; tick(); dat4 = 4'hA; tick();
    dat4 = 4'hC; tick(); dat4 = 4'h3; tick();
    dat4 = 4'h0; tick(); dat4 = 4'hF; tick();
    for (int i = 0; i < 5; i++) tick();
    #2 n_rst = 1'b0;
    #1;
    chk("t6_reset_busy", busy4, 0);
    chk("t6_reset_outs", {bd4, bi4, bv4, dn4, ce4, to4}, 0);
    tick(); tick();
    chk("t6_no_done_in_reset", dn4, 0);
    n_rst = 1'b1; tick();
    blk = '{8'h42, 8'h4D, 8'h36};
    push4(0, 8'h42); push4(1, 8'h4D); push4(2, 8'h36);
    exp4_done.push_back(2'b00);
    run4(4'hF, -1);
    chk("t6_clean_crc", ce4, 0);

    for (int i = 0; i < 5; i++) tick();
    chk("dut4_pending", exp4_dat.size() + exp4_done.size(), 0);
    chk("dut1_pending", exp1_dat.size() + exp1_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
